// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared types and constants for the FIR XIFU pipeline stages.
package fir_xifu_pkg;
    localparam int NB_REGS      = 4;
    localparam int REG_W        = $clog2(NB_REGS);
    localparam int DOTP_SHIFT_W = 5;
    localparam int ID_W         = 4;

    typedef logic [2:0] instr_t;
    localparam instr_t INSTR_INVALID  = 3'd0;
    localparam instr_t INSTR_XFIRLW   = 3'd1;
    localparam instr_t INSTR_XFIRSW   = 3'd2;
    localparam instr_t INSTR_XFIRDOTP = 3'd3;

    typedef enum logic [1:0] {EX_IDLE, EX_MEM_REQ, EX_HOLD} ex_state_e;

    typedef struct packed {
        instr_t                  instr;
        logic [ID_W-1:0]         id;
        logic [REG_W-1:0]        rd;
        logic [REG_W-1:0]        rs1;
        logic [REG_W-1:0]        rs2;
        logic [31:0]             rs1_val;
        logic [11:0]             imm;
        logic [31:0]             op_a;
        logic [31:0]             op_b;
        logic [DOTP_SHIFT_W-1:0] shift;
    } id2ex_t;

    typedef struct packed {
        instr_t           instr;
        logic [ID_W-1:0]  id;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [31:0]      result;
    } ex2wb_t;

    typedef struct packed {
        logic [2**ID_W-1:0] mem_issued;
    } ex2ctrl_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [31:0]      result;
        logic             we;
    } wb_fwd_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic            we;
        logic [3:0]      be;
        logic [2:0]      size;
    } mem_req_t;
endpackage

// File: rtl/fir_xifu_dotp.sv
// fir_xifu_dotp: packed 2x16 signed dot product followed by an arithmetic right shift.
// Defining FIR_XIFU_EX_SATURATE_EN clamps the shifted sum to the signed 32-bit range.
module fir_xifu_dotp
    import fir_xifu_pkg::*;
(
    input  logic [31:0]             op_a,
    input  logic [31:0]             op_b,
    input  logic [DOTP_SHIFT_W-1:0] shift,
    output logic [31:0]             result
);
    logic signed [31:0] p0, p1;
    logic signed [32:0] sum;
    assign p0  = 32'($signed(op_a[15:0])) * 32'($signed(op_b[15:0]));
    assign p1  = 32'($signed(op_a[31:16])) * 32'($signed(op_b[31:16]));
    assign sum = 33'(p0) + 33'(p1);
`ifdef FIR_XIFU_EX_SATURATE_EN
    logic signed [32:0] shifted;
    assign shifted = sum >>> shift;
    // bits 32 and 31 disagree only when the value leaves the 32-bit signed range
    assign result  = (shifted[32] != shifted[31]) ? {shifted[32], {31{~shifted[32]}}} : shifted[31:0];
`else
    assign result = 32'(sum >>> shift);
`endif
endmodule

// File: rtl/fir_xifu_ex.sv
// fir_xifu_ex: FIR XIFU execute stage; issues xfirlw/xfirsw memory requests and computes xfirdotp.
// Optional FIR_XIFU_EX_SATURATE_EN selects a saturating dot product.
module fir_xifu_ex
    import fir_xifu_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    output logic     xif_mem_valid_o,
    input  logic     xif_mem_ready_i,
    output mem_req_t xif_mem_req_o,
    input  id2ex_t   id2ex_i,
    input  logic     id_valid_i,
    output logic     ready_o,
    output ex2wb_t   ex2wb_o,
    input  logic     wb_ready_i,
    input  logic     kill_i,
    input  wb_fwd_t  wb_fwd_i,
    output ex2ctrl_t ex2ctrl_o
);
    ex_state_e   state;
    mem_req_t    req;
    ex2wb_t      pend;
    logic [31:0] op_a, op_b, dotp_res;
    logic        hs, is_mem, is_sw;

    assign op_a   = (wb_fwd_i.we && wb_fwd_i.rd == id2ex_i.rs1) ? wb_fwd_i.result : id2ex_i.op_a;
    assign op_b   = (wb_fwd_i.we && wb_fwd_i.rd == id2ex_i.rs2) ? wb_fwd_i.result : id2ex_i.op_b;
    assign is_sw  = id2ex_i.instr == INSTR_XFIRSW;
    assign is_mem = is_sw || id2ex_i.instr == INSTR_XFIRLW;

    assign ready_o         = state == EX_IDLE && (wb_ready_i || ex2wb_o.instr == INSTR_INVALID);
    // a kill withdraws the request unless the handshake completes in that very cycle
    assign xif_mem_valid_o = state == EX_MEM_REQ && (!kill_i || xif_mem_ready_i);
    assign hs              = xif_mem_valid_o && xif_mem_ready_i;
    assign xif_mem_req_o   = req;

    fir_xifu_dotp u_dotp (
        .op_a   (op_a),
        .op_b   (op_b),
        .shift  (id2ex_i.shift),
        .result (dotp_res)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state     <= EX_IDLE;
            req       <= '0;
            pend      <= '0;
            ex2wb_o   <= '0;
            ex2ctrl_o <= '0;
        end else begin
            ex2ctrl_o <= '0;
            if (hs) ex2ctrl_o.mem_issued[req.id] <= 1'b1;
            if (kill_i) begin
                state         <= EX_IDLE;
                ex2wb_o.instr <= INSTR_INVALID;
            end else case (state)
                EX_IDLE: if (ready_o) begin
                    ex2wb_o.instr <= INSTR_INVALID;
                    if (id_valid_i && is_mem) begin
                        req   <= '{id: id2ex_i.id, addr: id2ex_i.rs1_val, wdata: is_sw ? op_b : '0,
                                   we: is_sw, be: 4'hf, size: 3'b010};
                        pend  <= '{instr: id2ex_i.instr, id: id2ex_i.id, rd: id2ex_i.rd, rs1: id2ex_i.rs1,
                                   result: id2ex_i.rs1_val + {{20{id2ex_i.imm[11]}}, id2ex_i.imm}};
                        state <= EX_MEM_REQ;
                    end else if (id_valid_i && id2ex_i.instr == INSTR_XFIRDOTP)
                        ex2wb_o <= '{instr: INSTR_XFIRDOTP, id: id2ex_i.id, rd: id2ex_i.rd,
                                     rs1: id2ex_i.rs1, result: dotp_res};
                end
                EX_MEM_REQ: if (hs) begin
                    ex2wb_o <= pend;
                    state   <= wb_ready_i ? EX_IDLE : EX_HOLD;
                end
                EX_HOLD: if (wb_ready_i) begin
                    state         <= EX_IDLE;
                    ex2wb_o.instr <= INSTR_INVALID;
                end
                default: state <= EX_IDLE;
            endcase
        end
endmodule

// File: tb/tb_fir_xifu_ex.sv
// tb_fir_xifu_ex: randomized transaction-level bench for fir_xifu_ex with an in-bench model.
module tb_fir_xifu_ex;
    import fir_xifu_pkg::*;

    logic     clk_i = 1'b0, rst_ni = 1'b0;
    logic     xif_mem_valid_o, xif_mem_ready_i = 1'b0;
    mem_req_t xif_mem_req_o;
    id2ex_t   id2ex_i = '0;
    logic     id_valid_i = 1'b0, ready_o;
    ex2wb_t   ex2wb_o;
    logic     wb_ready_i = 1'b0, kill_i = 1'b0;
    wb_fwd_t  wb_fwd_i = '0;
    ex2ctrl_t ex2ctrl_o;

    int checks = 0, errors = 0;
    logic     chk_en = 1'b0;
    logic     exp_ready = 1'b1, exp_mv = 1'b0;
    mem_req_t exp_req = '0;
    ex2wb_t   exp_wb = '0, pend_wb = '0;
    ex2ctrl_t exp_ctrl = '0, nxt_ctrl = '0;

`ifdef FIR_XIFU_EX_SATURATE_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h8000_0000;
`endif
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 1;

    always #5 clk_i = ~clk_i;

    fir_xifu_ex dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .xif_mem_valid_o(xif_mem_valid_o), .xif_mem_ready_i(xif_mem_ready_i), .xif_mem_req_o(xif_mem_req_o),
        .id2ex_i(id2ex_i), .id_valid_i(id_valid_i), .ready_o(ready_o),
        .ex2wb_o(ex2wb_o), .wb_ready_i(wb_ready_i), .kill_i(kill_i),
        .wb_fwd_i(wb_fwd_i), .ex2ctrl_o(ex2ctrl_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) if (chk_en) begin
        chk("ready_o", 64'(ready_o), 64'(exp_ready));
        chk("mem_valid", 64'(xif_mem_valid_o), 64'(exp_mv));
        if (exp_mv) begin
            chk("mem_addr", 64'(xif_mem_req_o.addr), 64'(exp_req.addr));
            chk("mem_wdata", 64'(xif_mem_req_o.wdata), 64'(exp_req.wdata));
            chk("mem_we", 64'(xif_mem_req_o.we), 64'(exp_req.we));
            chk("mem_id", 64'(xif_mem_req_o.id), 64'(exp_req.id));
            chk("mem_be_size", 64'({xif_mem_req_o.be, xif_mem_req_o.size}), 64'({4'hf, 3'b010}));
        end
        chk("ex2wb", 64'(ex2wb_o), 64'(exp_wb));
        chk("mem_issued", 64'(ex2ctrl_o), 64'(exp_ctrl));
    end

    function automatic logic [31:0] dotp_model(input logic [31:0] a, input logic [31:0] b, input int sh);
        longint s;
        s = longint'($signed(a[15:0])) * longint'($signed(b[15:0]))
          + longint'($signed(a[31:16])) * longint'($signed(b[31:16]));
        s = s >>> sh;
`ifdef FIR_XIFU_EX_SATURATE_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] fwd(input logic [REG_W-1:0] idx, input logic [31:0] v);
        return (wb_fwd_i.we && wb_fwd_i.rd == idx) ? wb_fwd_i.result : v;
    endfunction

    function automatic id2ex_t rand_t();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[$bits(id2ex_t)-1:0];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic begin_cycle(input logic rf);
        exp_ctrl = nxt_ctrl;
        nxt_ctrl = '0;
        wb_fwd_i.rd = REG_W'($urandom);
        wb_fwd_i.result = $urandom;
        wb_fwd_i.we = rf & 1'($urandom);
    endtask

    task automatic idle_cycle(input logic wb, input logic kill);
        begin_cycle(1'b1);
        id_valid_i = 1'b0; wb_ready_i = wb; kill_i = kill; xif_mem_ready_i = 1'($urandom);
        exp_ready = wb || exp_wb.instr == INSTR_INVALID;
        exp_mv = 1'b0;
        tick();
        if (exp_ready || kill) exp_wb.instr = INSTR_INVALID;
        kill_i = 1'b0;
    endtask

    task automatic issue(input id2ex_t t, input logic rf);
        logic [31:0] a, b;
        logic sw;
        begin_cycle(rf);
        id2ex_i = t; id_valid_i = 1'b1; wb_ready_i = 1'b1; kill_i = 1'b0; xif_mem_ready_i = 1'($urandom);
        exp_ready = 1'b1; exp_mv = 1'b0;
        a = fwd(t.rs1, t.op_a);
        b = fwd(t.rs2, t.op_b);
        sw = t.instr == INSTR_XFIRSW;
        tick();
        id_valid_i = 1'b0;
        id2ex_i = rand_t();
        exp_wb.instr = INSTR_INVALID;
        if (t.instr == INSTR_XFIRDOTP)
            exp_wb = '{instr: t.instr, id: t.id, rd: t.rd, rs1: t.rs1, result: dotp_model(a, b, int'(t.shift))};
        if (sw || t.instr == INSTR_XFIRLW) begin
            exp_req = '{id: t.id, addr: t.rs1_val, wdata: sw ? b : 32'h0, we: sw, be: 4'hf, size: 3'b010};
            pend_wb = '{instr: t.instr, id: t.id, rd: t.rd, rs1: t.rs1, result: t.rs1_val + 32'($signed(t.imm))};
        end
    endtask

    task automatic mem_phase(input int delay, input logic wb_hs, input int kill_at);
        int n;
        for (int k = 0; k <= delay; k++) begin
            begin_cycle(1'b1);
            id2ex_i = rand_t(); id_valid_i = 1'($urandom);
            xif_mem_ready_i = k == delay;
            kill_i = k == kill_at;
            wb_ready_i = (k == delay) ? wb_hs : 1'($urandom);
            exp_ready = 1'b0;
            exp_mv = !kill_i || xif_mem_ready_i;
            if (xif_mem_ready_i) nxt_ctrl.mem_issued[exp_req.id] = 1'b1;
            tick();
            if (kill_i) begin
                exp_wb.instr = INSTR_INVALID;
                kill_i = 1'b0; id_valid_i = 1'b0;
                return;
            end
        end
        exp_wb = pend_wb;
        if (!wb_hs) begin
            n = $urandom_range(1, 3);
            for (int h = 0; h <= n; h++) begin
                begin_cycle(1'b1);
                id2ex_i = rand_t(); id_valid_i = 1'($urandom);
                wb_ready_i = h == n; kill_i = 1'b0; xif_mem_ready_i = 1'($urandom);
                exp_ready = 1'b0; exp_mv = 1'b0;
                tick();
            end
            exp_wb.instr = INSTR_INVALID;
        end
        id_valid_i = 1'b0; xif_mem_ready_i = 1'b0;
    endtask

    initial begin
        id2ex_t t;
        int sel, d, ka;
        chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 64'(ready_o), 64'(1));
        chk("rst_ex2wb", 64'(ex2wb_o), 64'(0));
        rst_ni = 1'b1;

        chk("model_dotp_basic", 64'(dotp_model(32'h0003_0002, 32'hFFFF_0004, 1)), 64'(32'h2));
        chk("model_dotp_ovf", 64'(dotp_model(32'h8000_8000, 32'h8000_8000, 0)), 64'(OVF_EXP));

        t = '0; t.instr = INSTR_XFIRLW; t.id = 4'd3; t.rs1_val = 32'h1000; t.imm = 12'd4;
        issue(t, 1'b0);
        mem_phase(3, 1'b1, -1);
        chk("lw_result", 64'(ex2wb_o.result), 64'(32'h1004));
        chk("lw_issued", 64'(ex2ctrl_o), 64'(16'h0008));
        idle_cycle(1'b1, 1'b0);

        t = '0; t.instr = INSTR_XFIRSW; t.id = 4'd5; t.rs1_val = 32'h2000; t.op_b = 32'hDEAD_BEEF;
        issue(t, 1'b0);
        chk("sw_wdata", 64'(xif_mem_req_o.wdata), 64'(32'hDEAD_BEEF));
        chk("sw_we", 64'(xif_mem_req_o.we), 64'(1));
        mem_phase(0, 1'b1, -1);
        chk("sw_ready_after", 64'(ready_o), 64'(1));

        t = '0; t.instr = INSTR_XFIRDOTP; t.op_a = 32'h0003_0002; t.op_b = 32'hFFFF_0004; t.shift = 5'd1;
        issue(t, 1'b0);
        chk("dotp_basic", 64'(ex2wb_o.result), 64'(32'h2));
        t.op_a = 32'h8000_8000; t.op_b = 32'h8000_8000; t.shift = 5'd0;
        issue(t, 1'b0);
        chk("dotp_ovf", 64'(ex2wb_o.result), 64'(OVF_EXP));

        t = '0; t.instr = INSTR_XFIRLW; t.id = 4'd1; t.rs1_val = 32'h0000_0FF0; t.imm = 12'hFFC;
        issue(t, 1'b0);
        mem_phase(1, 1'b0, -1);
        idle_cycle(1'b1, 1'b0);

        t = '0; t.instr = INSTR_XFIRLW; t.id = 4'd2; t.rs1_val = 32'h3000;
        issue(t, 1'b0);
        mem_phase(3, 1'b1, 1);
        chk("kill_no_issue", 64'(ex2ctrl_o), 64'(0));
        chk("kill_invalid", 64'(ex2wb_o.instr), 64'(INSTR_INVALID));

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) idle_cycle(1'($urandom), $urandom_range(0, 7) == 0);
            else begin
                t = rand_t();
                t.instr = sel < 5 ? INSTR_XFIRDOTP : sel < 7 ? INSTR_XFIRLW : sel < 9 ? INSTR_XFIRSW
                        : instr_t'($urandom_range(4, 7));
                issue(t, 1'b1);
                if (t.instr == INSTR_XFIRLW || t.instr == INSTR_XFIRSW) begin
                    d = $urandom_range(0, 3);
                    ka = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d)) : -1;
                    mem_phase(d, 1'($urandom), ka);
                end
            end
        end

        t = '0; t.instr = INSTR_XFIRLW; t.id = 4'd7; t.rs1_val = 32'h4000;
        issue(t, 1'b0);
        chk_en = 1'b0;
        xif_mem_ready_i = 1'b0; kill_i = 1'b0;
        #1;
        chk("pre_reset_valid", 64'(xif_mem_valid_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        chk("async_reset_valid", 64'(xif_mem_valid_o), 64'(0));
        chk("async_reset_ex2wb", 64'(ex2wb_o), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_xifu_ex.md
Name: fir_xifu_ex

Overview:
Execute stage of the FIR XIFU pipeline, between ID and WB. Issues the CV32E40X X-interface memory request for xfirlw/xfirsw and computes the post-incremented base address. Computes the xfirdotp packed 2x16-bit dot product. Registers the result into ex2wb_t for WB, with backpressure from WB and kill flush from the controller.

Parameters:
NB_REGS, 4, XIFU register-file depth; rd/rs index width is $clog2(NB_REGS).
DOTP_SHIFT_W, 5, width of the xfirdotp right-shift immediate.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
xif_mem_o  if  -  cv32e40x_if_xif.coproc_mem: mem_valid, mem_ready, mem_req (id, addr, wdata, we, be=4'hf, size=3'b010)
id2ex_i  in  id2ex_t  instr, id, rd, rs1, rs1_val (core GPR), imm (12b), op_a/op_b (XIFU regs), shift
id_valid_i  in  1  id2ex_i holds a valid instruction
ready_o  out  1  EX accepts id2ex_i this cycle
ex2wb_o  out  ex2wb_t  instr, id, rd, rs1, result
wb_ready_i  in  1  WB accepts ex2wb_o
kill_i  in  1  flush from WB/controller
wb_fwd_i  in  wb_fwd_t  WB write-back for operand forwarding (rd, result, we)
ex2ctrl_o  out  ex2ctrl_t  mem_issued[id] pulse for the scoreboard

Behaviour:
- Reset: FSM=IDLE; ex2wb_o='0 with instr=INSTR_INVALID; mem_valid=0; ready_o=1; ex2ctrl_o='0.
- FSM IDLE / MEM_REQ / HOLD.
- IDLE: ready_o = wb_ready_i | (ex2wb_o.instr==INSTR_INVALID). On id_valid_i & ready_o:
  - XFIRLW/XFIRSW: latch the request; go to MEM_REQ.
  - XFIRDOTP: register the result into ex2wb_o next cycle (1-cycle latency); stay IDLE.
  - other instr: ex2wb_o.instr<=INSTR_INVALID.
- MEM_REQ: mem_valid=1; addr=rs1_val; wdata=op_b (SW only); we=(instr==XFIRSW); id=latched id. ready_o=0. Request fields remain stable until mem_ready. On mem_valid & mem_ready: ex2ctrl_o.mem_issued[id]=1 for one cycle; load ex2wb_o (result=rs1_val+sign-extended imm, 32-bit wrap); go to HOLD if !wb_ready_i, else IDLE.
- HOLD: ready_o=0; ex2wb_o stays stable; go to IDLE when wb_ready_i.
- No ID instruction and WB ready in IDLE: ex2wb_o.instr<=INSTR_INVALID (bubble).
- xfirdotp: p0=$signed(op_a[15:0])*$signed(op_b[15:0]); p1=the same on [31:16]. sum is 33-bit signed; result = (sum >>> shift)[31:0].
- Forwarding: if wb_fwd_i.we and wb_fwd_i.rd equals an XIFU operand index, use wb_fwd_i.result.
- kill_i: FSM->IDLE; ex2wb_o.instr<=INSTR_INVALID next edge. If MEM_REQ is not yet accepted, drop mem_valid the same cycle. A handshake in the kill cycle still counts as issued.
- A memory handshake and a kill in the same cycle: kill wins for ex2wb_o; mem_issued still pulses.
- Reset mid-MEM_REQ: mem_valid drops asynchronously.

Optional Feature:
FIR_XIFU_EX_SATURATE_EN:
- Defined: after the shift, clamp the 33-bit value to [-2^31, 2^31-1] before truncation.
- Undefined: plain truncation. 0x8000*0x8000*2 then yields 0x80000000 at shift 0.

Decomposition:
- fir_xifu_pkg: id2ex_t, ex2wb_t, ex2ctrl_t, wb_fwd_t, ex_state_e, instr codes, DOTP_SHIFT_W.
- One sub-module: fir_xifu_dotp (combinational 2x16 MAC, shift, optional saturate), instantiated once.

Test Plan:
- XFIRLW with rs1_val=0x1000, imm=4, mem_ready delayed 3 cycles -> mem_valid held 3 cycles with addr=0x1000 stable; then ex2wb_o.result=0x1004; mem_issued pulses once.
- XFIRSW with op_b=0xDEADBEEF and immediate mem_ready -> we=1, wdata=0xDEADBEEF, 1-cycle request; ready_o back to 1 the next cycle.
- XFIRDOTP with op_a=0x00030002, op_b=0xFFFF0004, shift=1 -> result=(8-3)>>>1=2.
- XFIRDOTP with op_a=op_b=0x80008000, shift=0 -> 0x7FFFFFFF with SATURATE_EN, 0x80000000 without.
- wb_ready_i=0 during an LW handshake -> HOLD; ex2wb_o stable; ready_o=0 until wb_ready_i rises.
- kill_i in MEM_REQ before mem_ready -> mem_valid=0 the same cycle; ex2wb_o.instr=INSTR_INVALID; no mem_issued pulse.
